// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
//   slot_t      : one in-flight register write {valid, rd, avail}
//   fwd_src_e   : names for the bypass sources of the default 3-stage pipe
//   clamp_avail : maps a raw result-latency field onto 1..stages
// Slot fields are sized for the widest supported configuration
// (AW <= FWD_MAX_AW, STAGES < 2**FWD_MAX_SEL_W). Narrower values are
// zero-extended by the users, so one struct serves every parametrisation.
package fwd_pkg;

    localparam int FWD_MAX_AW    = 8;
    localparam int FWD_MAX_SEL_W = 4;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        SLOT_EX  = 2'd1,
        SLOT_MEM = 2'd2,
        SLOT_WB  = 2'd3
    } fwd_src_e;

    typedef struct packed {
        logic                     valid;
        logic [FWD_MAX_AW-1:0]    rd;
        logic [FWD_MAX_SEL_W-1:0] avail;
    } slot_t;

    // A latency of 0 means "as early as possible" (same as 1); anything
    // beyond the last tracked slot can only be bypassed from that slot.
    function automatic logic [FWD_MAX_SEL_W-1:0] clamp_avail(
        input logic [FWD_MAX_SEL_W-1:0] a,
        input int unsigned              stages
    );
        if (a == '0) begin
            return FWD_MAX_SEL_W'(1);
        end else if (32'(a) > stages) begin
            return FWD_MAX_SEL_W'(stages);
        end else begin
            return a;
        end
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-match lookup for one ID-stage source operand.
//   slots    : scoreboard contents, slot 1 = youngest (EX)
//   src      : source register number for this port
//   id_valid : instruction present in ID
//   sel      : 0 = register file, k = bypass from slot k
//   stall    : youngest producer has not yet produced its value
module fwd_match
    import fwd_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int AW     = 5,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  slot_t [STAGES:1] slots,
    input  logic  [AW-1:0]   src,
    input  logic             id_valid,
    output logic  [SEL_W-1:0] sel,
    output logic             stall
);

    always_comb begin : lookup
        logic found;
        found = 1'b0;
        sel   = SEL_W'(FWD_RF);
        stall = 1'b0;
        // Scan youngest first; the first hit shadows all older writers.
        for (int k = 1; k <= STAGES; k++) begin
            if (!found && slots[k].valid && slots[k].rd == FWD_MAX_AW'(src)) begin
                found = 1'b1;
                if (32'(slots[k].avail) > 32'(k)) begin
                    stall = id_valid;
                end else if (id_valid) begin
                    sel = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding / hazard unit for the pipelined MIPS core.
// A shift register of in-flight register writes (slot 1 = EX ... slot
// STAGES = WB) is searched for every ID source operand.
//   clk, rst      : clock and synchronous active-high reset
//   id_valid      : instruction present in ID
//   id_src        : NUM_RD_PORTS source registers, port p at [p*AW +: AW]
//   id_regwrite   : ID instruction writes id_rd
//   id_rd         : ID destination register
//   id_avail      : first slot whose bypass carries the result
//   pipe_freeze   : hold the whole scoreboard and the counter
//   ex_flush      : kill the instruction leaving ID
//   fwd_sel       : per-port bypass select (0 = register file)
//   stall         : hold PC/ID and insert a bubble into EX
//   stall_cnt     : saturating count of stall cycles
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_RD_PORTS = 2,
    parameter int AW           = 5,
    parameter int STAGES       = 3,
    parameter int SEL_W        = $clog2(STAGES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_RD_PORTS*AW-1:0]    id_src,
    input  logic                          id_regwrite,
    input  logic [AW-1:0]                 id_rd,
    input  logic [SEL_W-1:0]              id_avail,
    input  logic                          pipe_freeze,
    input  logic                          ex_flush,
    output logic [NUM_RD_PORTS*SEL_W-1:0] fwd_sel,
    output logic                          stall,
    output logic [31:0]                   stall_cnt
);

    slot_t [STAGES:1]          slot_q;
    slot_t [STAGES:1]          slot_d;
    logic  [31:0]              stall_cnt_q;
    logic  [31:0]              stall_cnt_d;
    logic  [NUM_RD_PORTS-1:0]  port_stall;
    logic                      insert;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        fwd_match #(
            .STAGES (STAGES),
            .AW     (AW),
            .SEL_W  (SEL_W)
        ) u_match (
            .slots    (slot_q),
            .src      (id_src[p*AW +: AW]),
            .id_valid (id_valid),
            .sel      (fwd_sel[p*SEL_W +: SEL_W]),
            .stall    (port_stall[p])
        );
    end

    // Per-port stalls are already gated by id_valid.
    assign stall     = |port_stall;
    assign stall_cnt = stall_cnt_q;

    // x0 and non-writing instructions never enter, so they can never match.
    assign insert = id_valid && id_regwrite && (id_rd != '0) && !stall && !ex_flush;

    always_comb begin
        slot_d      = slot_q;
        stall_cnt_d = stall_cnt_q;
        if (!pipe_freeze) begin
            for (int k = STAGES; k >= 2; k--) begin
                slot_d[k] = slot_q[k-1];
            end
            if (insert) begin
                slot_d[1].valid = 1'b1;
                slot_d[1].rd    = FWD_MAX_AW'(id_rd);
                slot_d[1].avail = clamp_avail(FWD_MAX_SEL_W'(id_avail), STAGES);
            end else begin
                slot_d[1] = '0;
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    // Only the valid bits need clearing; rd/avail are ignored while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= STAGES; k++) begin
                slot_q[k].valid <= 1'b0;
            end
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (2 read ports, AW=5, STAGES=3).
// Stimulus is applied just after each rising edge and the expected
// same-cycle outputs are queued; a monitor compares on the falling edge.
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_src;
    logic        id_regwrite;
    logic [4:0]  id_rd;
    logic [1:0]  id_avail;
    logic        pipe_freeze;
    logic        ex_flush;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]  s0;
        logic [1:0]  s1;
        logic        st;
        logic [31:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    fwd_scoreboard #(
        .NUM_RD_PORTS (2),
        .AW           (5),
        .STAGES       (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_regwrite (id_regwrite),
        .id_rd       (id_rd),
        .id_avail    (id_avail),
        .pipe_freeze (pipe_freeze),
        .ex_flush    (ex_flush),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    always @(negedge clk) begin : monitor
        exp_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (fwd_sel[1:0] !== e.s0 || fwd_sel[3:2] !== e.s1 ||
                stall !== e.st || stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got sel0=%0d sel1=%0d stall=%0b cnt=%h, want sel0=%0d sel1=%0d stall=%0b cnt=%h",
                         n, fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt,
                         e.s0, e.s1, e.st, e.cnt);
            end
        end
    end

    task automatic cyc(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic rw, input logic [4:0] rd, input logic [1:0] av,
                       input logic frz, input logic fl, input logic r, input logic chk,
                       input logic [1:0] e0, input logic [1:0] e1, input logic est,
                       input logic [31:0] ecnt, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        id_valid    = v;
        id_src      = {s1, s0};
        id_regwrite = rw;
        id_rd       = rd;
        id_avail    = av;
        pipe_freeze = frz;
        ex_flush    = fl;
        if (chk) begin
            e.s0 = e0; e.s1 = e1; e.st = est; e.cnt = ecnt;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
        end
    endtask

    localparam logic [31:0] SAT = 32'hFFFF_FFFF;

    initial begin
        rst = 1'b1; id_valid = 0; id_src = '0; id_regwrite = 0; id_rd = '0;
        id_avail = '0; pipe_freeze = 0; ex_flush = 0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "");
        //  v  s0  s1 rw rd av frz fl rst chk e0 e1 st cnt
        cyc(0, 3,  3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "reset_state");

        // ALU dependency
        cyc(1, 1,  2, 1, 3, 1, 0, 0, 0, 1, 0, 0, 0, 0, "alu_producer");
        cyc(1, 3,  4, 1, 6, 1, 0, 0, 0, 1, 1, 0, 0, 0, "alu_ex_bypass");
        cyc(1, 3,  3, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, "alu_mem_bypass");
        cyc(0, 3,  3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "no_valid_no_fwd");
        cyc(1, 6,  0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, "wb_bypass");

        // Load-use
        cyc(1, 0,  0, 1, 5, 2, 0, 0, 0, 1, 0, 0, 0, 0, "load_issue");
        cyc(1, 5,  9, 1,10, 1, 0, 0, 0, 1, 0, 0, 1, 0, "load_use_stall");
        cyc(1, 5,  9, 1,10, 1, 0, 0, 0, 1, 2, 0, 0, 1, "load_use_fwd");
        cyc(0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, "load_idle_cnt");
        idle(3);

        // Youngest wins (first writer uses avail 0, treated as 1)
        cyc(1, 0,  0, 1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 1, "yw_write_old");
        cyc(1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, "yw_gap");
        cyc(1, 0,  0, 1, 7, 1, 0, 0, 0, 1, 0, 0, 0, 1, "yw_write_new");
        cyc(1, 7,  7, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, "youngest_alu");
        idle(3);
        cyc(1, 0,  0, 1, 7, 1, 0, 0, 0, 1, 0, 0, 0, 1, "yw2_write_old");
        cyc(1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, "yw2_gap");
        cyc(1, 0,  0, 1, 7, 2, 0, 0, 0, 1, 0, 0, 0, 1, "yw2_write_load");
        cyc(1, 7,  7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, "youngest_load_stall");
        cyc(1, 7,  7, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 2, "youngest_load_fwd");
        idle(3);

        // r0 and non-writing producers
        cyc(1, 0,  0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2, "r0_write");
        cyc(1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, "r0_read");
        cyc(1, 0,  0, 0, 8, 1, 0, 0, 0, 1, 0, 0, 0, 2, "nowrite_r8");
        cyc(1, 8,  8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, "nowrite_read");
        idle(3);

        // Freeze during a load-use stall (consumer on port 1)
        cyc(1, 0,  0, 1, 5, 2, 0, 0, 0, 1, 0, 0, 0, 2, "frz_load");
        cyc(1, 1,  5, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 2, "freeze_1");
        cyc(1, 1,  5, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 2, "freeze_2");
        cyc(1, 1,  5, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 2, "freeze_3");
        cyc(1, 1,  5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, "unfreeze_stall");
        cyc(1, 1,  5, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 3, "unfreeze_fwd");
        idle(3);

        // Flush
        cyc(1, 0,  0, 1, 9, 1, 0, 1, 0, 1, 0, 0, 0, 3, "flush_producer");
        cyc(1, 9,  9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, "flushed_no_fwd");
        cyc(1, 0,  0, 1, 5, 2, 0, 0, 0, 1, 0, 0, 0, 3, "fs_load");
        cyc(1, 5,  0, 1,14, 1, 0, 1, 0, 1, 0, 0, 1, 3, "stall_and_flush");
        cyc(1, 5,  0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 4, "after_stall_flush");
        idle(3);

        // Reset mid-operation
        cyc(1, 0,  0, 1,11, 1, 0, 0, 0, 1, 0, 0, 0, 4, "fill_r11");
        cyc(1, 0,  0, 1,12, 1, 0, 0, 0, 1, 0, 0, 0, 4, "fill_r12");
        cyc(1, 0,  0, 1,13, 2, 0, 0, 0, 1, 0, 0, 0, 4, "fill_r13");
        cyc(1,13, 12, 0, 0, 0, 0, 0, 1, 1, 0, 2, 1, 4, "pre_reset_state");
        cyc(1,13, 11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "post_reset_clear");
        idle(3);

        // Saturation: preload the counter just below the top
        #2;
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        cyc(1, 0,  0, 1, 5, 3, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFD, "sat_load");
        cyc(1, 5,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFD, "sat_stall_1");
        cyc(1, 5,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFE, "sat_stall_2");
        cyc(1, 5,  0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, SAT,           "sat_reach");
        cyc(1, 0,  0, 1, 5, 3, 0, 0, 0, 1, 0, 0, 0, SAT,           "sat_load2");
        cyc(1, 5,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, SAT,           "sat_hold_1");
        cyc(1, 5,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, SAT,           "sat_hold_2");
        cyc(1, 5,  0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, SAT,           "sat_hold_3");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

- Parametrised forwarding/hazard unit for the pipelined MIPS core.
- Keeps a shift-register scoreboard of in-flight register writes, one slot per pipeline stage after ID (slot 1 = EX … slot STAGES = WB).
- For each ID-stage source operand it produces a bypass select, and it raises a stall when the youngest producer's value is not yet available.
- Supports any number of read ports, pipeline depth, per-instruction result latency, pipeline freeze, EX flush, and a stall performance counter.

## Interface
Parameters:
- NUM_RD_PORTS, 2, ID-stage source operands checked per cycle
- AW, 5, register address width
- STAGES, 3, tracked stages after ID (EX, MEM, WB)
- SEL_W, $clog2(STAGES+1), width of one bypass select / latency field

Ports (single clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  instruction present in ID
- id_src  in  NUM_RD_PORTS*AW  source register numbers; port p at [p*AW +: AW]
- id_regwrite  in  1  ID instruction writes a register
- id_rd  in  AW  ID destination register
- id_avail  in  SEL_W  first slot whose bypass carries the result (1 = ALU at EX output, 2 = load at MEM output, …)
- pipe_freeze  in  1  whole pipeline held (e.g. cache miss)
- ex_flush  in  1  kill the instruction leaving ID (mispredict)
- fwd_sel  out  NUM_RD_PORTS*SEL_W  per port: 0 = register file, k = bypass from slot k
- stall  out  1  hold PC/ID, insert bubble into EX
- stall_cnt  out  32  saturating count of stall cycles

## Operation
- Each slot k holds {valid, rd, avail}. Entries with rd = 0 or id_regwrite = 0 are never inserted, so x0 is never forwarded.
- Match for port p: a slot k that is valid and has rd == id_src[p]. Only the youngest match (smallest k) counts; older matches are ignored.
- fwd_sel[p] = k when the youngest match has k >= avail. It is 0 when there is no match or id_valid = 0.
- stall = id_valid AND, on any port, the youngest match has avail > k. While stalled, fwd_sel for that port is 0.
- id_avail = 0 is treated as 1. Values above STAGES are clamped to STAGES.
- Slot update on each edge when not rst and not pipe_freeze:
  - slot[k+1] <= slot[k] for k = 1..STAGES-1;
  - slot STAGES is discarded;
  - slot 1 <= the ID instruction if id_valid & id_regwrite & id_rd != 0 & !stall & !ex_flush, else a bubble (valid = 0).
- pipe_freeze = 1: all slots hold and stall_cnt holds. fwd_sel and stall are still driven combinationally from the held state.
- stall_cnt increments by 1 on every edge where stall & !pipe_freeze, and saturates at 32'hFFFF_FFFF.

## Timing
- fwd_sel and stall are purely combinational from the current slots and the ID inputs (same-cycle, zero latency).
- Scoreboard state and stall_cnt update on the rising clk edge.
- Reset: all slots invalid, stall_cnt = 0. Therefore fwd_sel = 0 and stall = 0 in the first cycle after reset.
- rst has priority over pipe_freeze and ex_flush.
- Reset asserted mid-stall clears the stall on the next cycle. Any pending producer is lost; this is intended because the pipeline is flushed with it.
- A load followed immediately by its consumer (avail = 2):
  - cycle n: load in slot 1, stall = 1, a bubble is inserted;
  - cycle n+1: load in slot 2, fwd_sel = 2, stall = 0.
- stall and ex_flush in the same cycle: a bubble is inserted either way, and stall_cnt still increments.

## Structure
- Shared package `fwd_pkg`:
  - slot struct {valid, rd, avail};
  - constants FWD_RF = 0, SLOT_EX = 1, SLOT_MEM = 2, SLOT_WB = 3;
  - function clamp_avail.
- Sub-module `fwd_match`: one instance per read port. Inputs are the slot vector and one source register; outputs are youngest-match sel and per-port stall.
- The top level ORs the per-port stalls and owns the slot registers and stall_cnt.

## Test plan
- ALU dependency: `add r3` (avail 1) followed by `sub` using r3 on port 0 → next cycle fwd_sel[0] = 1, stall = 0; one cycle later a reader of r3 sees fwd_sel = 2.
- Load-use: `lw r5` (avail 2) followed by a reader of r5 → stall = 1 for exactly 1 cycle, then fwd_sel = 2, stall_cnt = 1.
- Youngest wins:
  - writes to r7 are in slot 3 and slot 1 (avail 1), ID reads r7 on both ports → fwd_sel = {1, 1};
  - with slot 1 having avail = 2 instead → stall = 1, and slot 3 is not used.
- r0 and no-write: an instruction with id_rd = 0, or with id_regwrite = 0, followed by readers of that register → fwd_sel = 0 and no stall.
- Freeze and flush:
  - pipe_freeze held 3 cycles during a load-use stall → slots unchanged, stall stays 1, stall_cnt unchanged;
  - ex_flush on the producer → its consumer gets fwd_sel = 0.
- Reset mid-operation: full scoreboard, then rst for 1 cycle → all fwd_sel = 0, stall = 0, stall_cnt = 0.
- Saturation: force stall_cnt to all-ones via a long stall → it stays at 32'hFFFF_FFFF.
